// File: rtl/fpro_uart_bus_master.sv
// Byte-stream debug bridge acting as initiator on the FPro MMIO bus.
// Parses 'W' (write) and 'R' (read) commands from an rx byte stream, issues
// one single-cycle bus transaction, and returns an ACK, NAK or read data
// bytes on a tx byte stream.
module fpro_uart_bus_master #(
    parameter int          TIMEOUT_CYC = 50_000_000,
    parameter logic [7:0]  ACK_BYTE    = 8'h4B,
    parameter logic [7:0]  NAK_BYTE    = 8'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy,
    output logic        err
);

    localparam int            TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    state_t        state_q;
    logic          isWrite_q;
    logic [1:0]    byteCnt_q;
    logic [15:0]   addrShift_q;
    logic [23:0]   dataShift_q;
    logic [23:0]   respShift_q;
    logic [1:0]    respLeft_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    txData_q;
    logic          txValid_q;
    logic          cs_q;
    logic          wr_q;
    logic          rd_q;
    logic [20:0]   addr_q;
    logic [31:0]   wrData_q;
    logic          err_q;
    logic          rxFire;

    assign rx_ready     = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    assign rxFire       = rx_valid && rx_ready;
    assign busy         = (state_q != IDLE);
    assign tx_data      = txData_q;
    assign tx_valid     = txValid_q;
    assign mmio_cs      = cs_q;
    assign mmio_wr      = wr_q;
    assign mmio_rd      = rd_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wrData_q;
    assign err          = err_q;

    // Command parser, bus sequencer and response serializer in one FSM;
    // strobes and err default low so they can only ever last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            isWrite_q   <= 1'b0;
            byteCnt_q   <= '0;
            addrShift_q <= '0;
            dataShift_q <= '0;
            respShift_q <= '0;
            respLeft_q  <= '0;
            tmo_q       <= '0;
            txData_q    <= '0;
            txValid_q   <= 1'b0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wrData_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            cs_q  <= 1'b0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rxFire) begin
                        if (rx_data == 8'h57 || rx_data == 8'h52) begin
                            isWrite_q <= (rx_data == 8'h57);
                            byteCnt_q <= '0;
                            tmo_q     <= '0;
                            state_q   <= ADDR;
                        end else begin
                            err_q      <= 1'b1;
                            txData_q   <= NAK_BYTE;
                            txValid_q  <= 1'b1;
                            respLeft_q <= '0;
                            state_q    <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (rxFire) begin
                        tmo_q       <= '0;
                        addrShift_q <= {addrShift_q[7:0], rx_data};
                        byteCnt_q   <= byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd2) begin
                            addr_q <= {addrShift_q[12:0], rx_data};
                            if (isWrite_q) begin
                                byteCnt_q <= '0;
                                state_q   <= DATA;
                            end else begin
                                cs_q    <= 1'b1;
                                rd_q    <= 1'b1;
                                state_q <= BUS;
                            end
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                DATA: begin
                    if (rxFire) begin
                        tmo_q       <= '0;
                        dataShift_q <= {dataShift_q[15:0], rx_data};
                        byteCnt_q   <= byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            wrData_q <= {dataShift_q, rx_data};
                            cs_q     <= 1'b1;
                            wr_q     <= 1'b1;
                            state_q  <= BUS;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                BUS: begin
                    txValid_q <= 1'b1;
                    if (isWrite_q) begin
                        txData_q   <= ACK_BYTE;
                        respLeft_q <= 2'd0;
                    end else begin
                        txData_q    <= mmio_rd_data[31:24];
                        respShift_q <= mmio_rd_data[23:0];
                        respLeft_q  <= 2'd3;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (tx_ready) begin
                        if (respLeft_q == 2'd0) begin
                            txValid_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            txData_q    <= respShift_q[23:16];
                            respShift_q <= {respShift_q[15:0], 8'h00};
                            respLeft_q  <= respLeft_q - 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpro_uart_bus_master.sv
// Scoreboard bench for fpro_uart_bus_master: directed commands push expected
// bus transactions and tx bytes into queues, a monitor pops and compares them.
module tb_fpro_uart_bus_master;

    typedef struct {
        logic        wr;
        logic [20:0] addr;
        logic [31:0] data;
    } busTxn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          errPulses = 0;
    int          expErrPulses = 0;
    logic        errPrev = 1'b0;
    logic [7:0]  expTx[$];
    busTxn_t     expBus[$];

    fpro_uart_bus_master #(
        .TIMEOUT_CYC(16),
        .ACK_BYTE(8'h4B),
        .NAK_BYTE(8'h3F)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .mmio_cs(mmio_cs),
        .mmio_wr(mmio_wr),
        .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr),
        .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data),
        .busy(busy),
        .err(err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Slot model: one special register, every other address returns CAFE in the top half
    assign mmio_rd_data = (mmio_addr == 21'h10203) ? 32'h12345678 : {16'hCAFE, mmio_addr[15:0]};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        logic acc;
        int   waitCyc;
        acc     = 1'b0;
        waitCyc = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && waitCyc < 100) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            waitCyc++;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL rxAccept actual=stalled required=accepted byte=%0h", b);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        checkOutput("returnIdle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: pop and compare on every tx transfer and bus strobe, track err pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                if (expTx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedTx actual=%0h required=none", tx_data);
                end else begin
                    checkOutput("txByte", {24'd0, tx_data}, {24'd0, expTx.pop_front()});
                end
            end
            if (mmio_cs) begin
                if (expBus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedBus actual=addr %0h required=none", mmio_addr);
                end else begin
                    busTxn_t t;
                    t = expBus.pop_front();
                    checkOutput("busWr", {31'd0, mmio_wr}, {31'd0, t.wr});
                    checkOutput("busRd", {31'd0, mmio_rd}, {31'd0, ~t.wr});
                    checkOutput("busAddr", {11'd0, mmio_addr}, {11'd0, t.addr});
                    if (t.wr) checkOutput("busWrData", mmio_wr_data, t.data);
                end
            end else if (mmio_wr || mmio_rd) begin
                checks++;
                errors++;
                $display("[TB] FAIL strobeWithoutCs actual=wr%0b rd%0b required=0", mmio_wr, mmio_rd);
            end
            if (err) errPulses++;
            if (err && errPrev) begin
                checks++;
                errors++;
                $display("[TB] FAIL errPulseWidth actual=2+ cycles required=1");
            end
        end
        errPrev = err;
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int n;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRxReady", {31'd0, rx_ready}, 32'd1);
        checkOutput("rstTxValid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstCs", {31'd0, mmio_cs}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Write 0xDEADBEEF to 0x00045, check latency of strobe and ACK
        expBus.push_back('{wr: 1'b1, addr: 21'h00045, data: 32'hDEADBEEF});
        expTx.push_back(8'h4B);
        applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h45);
        applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
        @(negedge clk);
        checkOutput("strobeLatency", {31'd0, mmio_cs}, 32'd1);
        @(negedge clk);
        checkOutput("txLatency", {31'd0, tx_valid}, 32'd1);
        checkOutput("ackByte", {24'd0, tx_data}, 32'h4B);
        @(negedge clk);
        checkOutput("busyAfterAck", {31'd0, busy}, 32'd0);
        checkOutput("wrDataHold", mmio_wr_data, 32'hDEADBEEF);

        // Read 0x10203 with A2[7:5] set, response held off by back-pressure
        @(posedge clk);
        #1 tx_ready = 1'b0;
        expBus.push_back('{wr: 1'b0, addr: 21'h10203, data: 32'h0});
        expTx.push_back(8'h12); expTx.push_back(8'h34); expTx.push_back(8'h56); expTx.push_back(8'h78);
        applyStimulus(8'h52); applyStimulus(8'hE1); applyStimulus(8'h02); applyStimulus(8'h03);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 20);
        for (int i = 0; i < 10; i++) begin
            checkOutput("stallTxData", {24'd0, tx_data}, 32'h12);
            checkOutput("stallTxValid", {31'd0, tx_valid}, 32'd1);
            checkOutput("stallRxReady", {31'd0, rx_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        waitIdle();
        checkOutput("addrHold", {11'd0, mmio_addr}, {11'd0, 21'h10203});

        // Unknown opcode: err pulse and NAK, then a normal read
        @(posedge clk);
        #1;
        expTx.push_back(8'h3F);
        expErrPulses++;
        applyStimulus(8'h41);
        @(negedge clk);
        checkOutput("nakErr", {31'd0, err}, 32'd1);
        checkOutput("nakTxValid", {31'd0, tx_valid}, 32'd1);
        checkOutput("nakByte", {24'd0, tx_data}, 32'h3F);
        waitIdle();
        @(posedge clk);
        #1;
        expBus.push_back('{wr: 1'b0, addr: 21'h00045, data: 32'h0});
        expTx.push_back(8'hCA); expTx.push_back(8'hFE); expTx.push_back(8'h00); expTx.push_back(8'h45);
        applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h45);
        waitIdle();

        // Timeout after a partial write: err 15 cycles after the last byte
        @(posedge clk);
        #1;
        expErrPulses++;
        applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h00);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (err) break;
        end
        checkOutput("timeoutDelay", n, 32'd15);
        checkOutput("timeoutIdle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        expBus.push_back('{wr: 1'b1, addr: 21'h00102, data: 32'h11223344});
        expTx.push_back(8'h4B);
        applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h02);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
        waitIdle();

        // Reset in the middle of a read command, then a clean read
        @(posedge clk);
        #1;
        applyStimulus(8'h52); applyStimulus(8'h00);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstRxReady", {31'd0, rx_ready}, 32'd1);
        checkOutput("midRstTxData", {24'd0, tx_data}, 32'd0);
        checkOutput("midRstAddr", {11'd0, mmio_addr}, 32'd0);
        checkOutput("midRstWrData", mmio_wr_data, 32'd0);
        checkOutput("midRstErr", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expBus.push_back('{wr: 1'b0, addr: 21'h00001, data: 32'h0});
        expTx.push_back(8'hCA); expTx.push_back(8'hFE); expTx.push_back(8'h00); expTx.push_back(8'h01);
        applyStimulus(8'h52); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h01);
        waitIdle();

        repeat (5) @(negedge clk);
        checkOutput("txQueueEmpty", expTx.size(), 32'd0);
        checkOutput("busQueueEmpty", expBus.size(), 32'd0);
        checkOutput("errPulseCount", errPulses, expErrPulses);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpro_uart_bus_master.md
Name: fpro_uart_bus_master

Overview:
- Byte-stream debug bridge that acts as the initiator side of the FPro MMIO bus.
- Parses command bytes, typically from a UART receive FIFO, and issues single read or write transactions to the mmio controller.
- Returns acknowledge or read-data bytes on a transmit byte stream.
- Lets a host PC peek and poke any slot register without the processor, e.g. muxed in front of the mmio subsystem for bring-up.

Parameters:
- TIMEOUT_CYC, 50_000_000, idle cycles allowed between bytes of a partial command before abort; must be >= 2.
- ACK_BYTE, 8'h4B, response byte after a completed write ('K').
- NAK_BYTE, 8'h3F, response byte after an unknown opcode ('?').

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  incoming command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data this cycle
- tx_data  out  8  outgoing response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data this cycle
- mmio_cs  out  1  FPro bus chip select
- mmio_wr  out  1  FPro bus write strobe
- mmio_rd  out  1  FPro bus read strobe
- mmio_addr  out  21  FPro bus word address
- mmio_wr_data  out  32  FPro bus write data
- mmio_rd_data  in  32  FPro bus read data; combinational from the slot in the strobe cycle
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on unknown opcode or timeout

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high; all state resets in the cycle reset is sampled high.
  - Reset values: state=IDLE; rx_ready=1; tx_valid=0; tx_data=0; mmio_cs/wr/rd=0; mmio_addr=0; mmio_wr_data=0; busy=0; err=0.
  - Reset mid-command discards the partial command, any pending response and all counters. No bus strobe is issued.
- Handshakes:
  - A byte is accepted when rx_valid && rx_ready.
  - A byte is sent when tx_valid && tx_ready.
  - tx_data and tx_valid hold stable until accepted. tx_valid never drops without a transfer.
- Command format, multi-byte fields big-endian:
  - Write: 0x57 ('W'), A2, A1, A0, D3, D2, D1, D0.
  - Read: 0x52 ('R'), A2, A1, A0.
  - mmio_addr = {A2[4:0], A1, A0}; A2[7:5] are ignored.
- States:
  - IDLE: rx_ready=1.
    - 'W' or 'R': latch the opcode and go to ADDR with byte cnt=0.
    - Any other byte: err=1 for one cycle, load NAK_BYTE, go to RESP with 1 byte to send. No bus activity.
  - ADDR: rx_ready=1. Shift in 3 address bytes.
    - After A0: write goes to DATA (cnt=0); read goes to BUS.
  - DATA: rx_ready=1. Shift in 4 data bytes; after D0 go to BUS.
  - BUS: exactly one cycle, rx_ready=0.
    - mmio_cs=1, plus mmio_wr=1 (write) or mmio_rd=1 (read), never both.
    - mmio_addr and mmio_wr_data are registered, already valid in this cycle, and hold their values afterwards until the next command overwrites them.
    - Read: capture mmio_rd_data at the end of this cycle.
    - Then go to RESP: write sends 1 byte (ACK_BYTE); read sends 4 bytes, MSB first.
  - RESP: rx_ready=0, tx_valid=1. Advance to the next byte on each transfer. After the last transfer, tx_valid=0 and state returns to IDLE.
- Latency:
  - Final command byte accepted in cycle N → bus strobe in cycle N+1.
  - tx_valid=1 with the first response byte in cycle N+2.
  - Unknown opcode accepted in cycle N → tx_valid=1 in cycle N+1.
- Timeout:
  - Applies in ADDR and DATA only.
  - The counter increments each cycle with no accepted byte and clears on every accepted byte.
  - On reaching TIMEOUT_CYC-1: err=1 for one cycle, return to IDLE, send no response, issue no bus activity.
- Back-pressure: tx_ready low indefinitely stalls in RESP with no timeout. rx_ready stays 0 throughout.
- Bus strobes are single-cycle and are never issued outside BUS. Consecutive commands never produce back-to-back strobes; a RESP phase always separates them.

Test Plan:
- Write: rx 57 00 00 45 DE AD BE EF → one cycle with mmio_cs=1, mmio_wr=1, mmio_addr=21'h00045, mmio_wr_data=32'hDEADBEEF; then tx 4B; busy falls after the ACK transfer.
- Read: rx 52 E1 02 03 with the slot model returning 32'h12345678 for address 21'h10203 → one cycle with mmio_cs=1, mmio_rd=1, mmio_addr=21'h10203 (A2[7:5] ignored); tx 12 34 56 78 in order.
- Back-pressure: during the read response hold tx_ready=0 for 10 cycles → tx_data stays 8'h12 with tx_valid=1; rx_ready=0; no extra bus strobes; the remaining bytes follow when tx_ready=1.
- Bad opcode: rx 41 → err pulses 1 cycle, tx 3F, mmio_cs never asserted; a following read command completes normally.
- Timeout (TIMEOUT_CYC=16): rx 57 00 00, then silence → err pulses 15 cycles after the last accepted byte; state IDLE; no tx output and no bus strobe. A subsequent valid write executes correctly.
- Reset mid-command: rx 52 00, assert reset 1 cycle, then rx 52 00 00 01 → all outputs return to reset values; exactly one read strobe, at address 21'h00001.
